// File: rtl/stage_fetch.sv
// stage_fetch: owns the PC, captures fetched words into a 2-entry queue, and hands {instr, pc} to decode.
module stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] PC_value,
    input  logic [31:0] read_data_0,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] fetch_count
);
    logic [31:0] pc_q, pc_d, fcnt_q, fcnt_d;
    logic [31:0] head_instr_q, head_instr_d, head_pc_q, head_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d, tail_pc_q, tail_pc_d;
    logic [1:0]  count_q, count_d;
    logic        pop, push, head_takes_new, shift;

    assign instr_valid    = count_q != 2'd0;
    assign pop            = instr_valid & instr_ready;
    assign push           = fetch_en & ~redirect_valid & (count_q != 2'd2 | pop);
    // The new word lands in the head slot when the queue is or is becoming empty.
    assign head_takes_new = count_q == 2'd0 | (count_q == 2'd1 & pop);
    assign shift          = pop & count_q == 2'd2;

    always_comb begin
        pc_d         = redirect_valid ? redirect_pc : push ? pc_q + PC_STEP : pc_q;
        count_d      = redirect_valid ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        fcnt_d       = fcnt_q + {31'd0, push};
        head_instr_d = (push & head_takes_new) ? read_data_0 : shift ? tail_instr_q : head_instr_q;
        head_pc_d    = (push & head_takes_new) ? pc_q : shift ? tail_pc_q : head_pc_q;
        tail_instr_d = (push & ~head_takes_new) ? read_data_0 : tail_instr_q;
        tail_pc_d    = (push & ~head_takes_new) ? pc_q : tail_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            count_q      <= 2'd0;
            fcnt_q       <= 32'd0;
            head_instr_q <= 32'd0;
            head_pc_q    <= 32'd0;
            tail_instr_q <= 32'd0;
            tail_pc_q    <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            fcnt_q       <= fcnt_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

    assign PC_value    = pc_q;
    assign instr       = head_instr_q;
    assign instr_pc    = head_pc_q;
    assign fetch_count = fcnt_q;
endmodule

// File: tb/tb_stage_fetch.sv
// tb_stage_fetch: directed vector table, hand-written reset corner case, and randomized run against a queue model.
module tb_stage_fetch;
    logic        clk = 1'b0, rst_n = 1'b0, fetch_en = 1'b0, redirect_valid = 1'b0, instr_ready = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] PC_value, read_data_0, instr, instr_pc, fetch_count;
    logic        instr_valid;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h1:   return 32'h22;
            32'h2:   return 32'h33;
            32'h40:  return 32'hAB;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
        endcase
    endfunction

    assign read_data_0 = mem_f(PC_value);

    stage_fetch dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .PC_value(PC_value), .read_data_0(read_data_0),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fetch_count(fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] eipc;
        logic [31:0] epc;
        logic [31:0] efc;
    } vec_t;

    vec_t vt[17];

    // Reference model: a plain queue of {instr, pc} plus PC and push counter.
    logic [63:0] mq[$];
    logic [31:0] mpc, mfc;

    task automatic model_reset();
        mq.delete();
        mpc = 32'h0;
        mfc = 32'd0;
    endtask

    task automatic model_edge(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        bit do_pop, do_push;
        do_pop  = mq.size() > 0 && rdy;
        do_push = fe && !rv && (mq.size() < 2 || do_pop);
        if (rv) begin
            mq.delete();
            mpc = rpc;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({mem_f(mpc), mpc});
                mpc = mpc + 32'd1;
                mfc = mfc + 32'd1;
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h11, 32'h0, 32'h1, 32'd1};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h22, 32'h1, 32'h2, 32'd2};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h33, 32'h2, 32'h3, 32'd3};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h11, 32'h0, 32'h1, 32'd1};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h11, 32'h0, 32'h2, 32'd2};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h11, 32'h0, 32'h2, 32'd2};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h11, 32'h0, 32'h2, 32'd2};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h22, 32'h1, 32'h3, 32'd3};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h22, 32'h1, 32'h3, 32'd3};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h33, 32'h2, 32'h4, 32'd4};
        vt[10] = '{1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0, 32'h40, 32'd4};
        vt[11] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'hAB, 32'h40, 32'h41, 32'd5};
        vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, mem_f(32'h41), 32'h41, 32'h42, 32'd6};
        vt[13] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, mem_f(32'h41), 32'h41, 32'h43, 32'd7};
        vt[14] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, mem_f(32'h42), 32'h42, 32'h43, 32'd7};
        vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0, 32'h43, 32'd7};
        vt[16] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0, 32'h43, 32'd7};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", PC_value, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_fcount", fetch_count, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            if (vt[i].rst) pulse_reset();
            fetch_en = vt[i].fe;
            redirect_valid = vt[i].rv;
            redirect_pc = vt[i].rpc;
            instr_ready = vt[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, vt[i].ev});
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_instr", i), instr, vt[i].ei);
                chk($sformatf("vec%0d_instr_pc", i), instr_pc, vt[i].eipc);
            end
            chk($sformatf("vec%0d_pc", i), PC_value, vt[i].epc);
            chk($sformatf("vec%0d_fcount", i), fetch_count, vt[i].efc);
        end

        // Asynchronous reset with a full queue, between clock edges.
        fetch_en = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("full_valid", {31'd0, instr_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_rst_pc", PC_value, 32'h0);
        chk("async_rst_fcount", fetch_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_instr", instr, 32'h11);
        chk("restart_instr_pc", instr_pc, 32'h0);
        chk("restart_pc", PC_value, 32'h1);

        // Randomized run against the queue model.
        pulse_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            fetch_en = ($urandom_range(0, 9) < 8);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom_range(0, 255);
            instr_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk);
            model_edge(fetch_en, redirect_valid, redirect_pc, instr_ready);
            #1;
            chk("rnd_valid", {31'd0, instr_valid}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) begin
                chk("rnd_instr", instr, mq[0][63:32]);
                chk("rnd_instr_pc", instr_pc, mq[0][31:0]);
            end
            chk("rnd_pc", PC_value, mpc);
            chk("rnd_fcount", fetch_count, mfc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stage_fetch.md
# stage_fetch

Instruction-fetch stage directly upstream of `stage_memory`. Owns the program counter and drives `PC_value` into the memory stage. Captures the instruction word returned on `read_data_0` into a 2-entry instruction queue, which presents {instruction, PC} to decode through a valid/ready handshake. Supports decode back-pressure, fetch halt, and PC redirect from execute (branch/jump), which flushes the queue.

## Interface
Parameters:
- `RESET_PC`, default 32'h0: PC value loaded on reset.
- `PC_STEP`, default 32'd1: PC increment per fetched instruction; word addressing.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_en`  in  1  fetch allowed; low = halt, PC holds.
- `redirect_valid`  in  1  load PC from `redirect_pc` and flush the queue.
- `redirect_pc`  in  32  new PC target.
- `PC_value`  out  32  fetch address to `stage_memory`; always equals the PC register.
- `read_data_0`  in  32  instruction word at `PC_value`; combinational read, valid in the same cycle.
- `instr_valid`  out  1  queue head holds a valid instruction.
- `instr`  out  32  queue head instruction word.
- `instr_pc`  out  32  PC of the queue head.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `fetch_count`  out  32  number of instructions pushed since reset; wraps modulo 2^32.

## Operation
- State:
  - PC register.
  - 2-entry FIFO of {instr, pc} with a 2-bit occupancy count (0..2).
  - `fetch_count` register.
- pop = `instr_valid & instr_ready`.
- push = `fetch_en & ~redirect_valid & (count<2 | pop)`.
- On push:
  - Enqueue {`read_data_0`, PC}.
  - PC <= PC + `PC_STEP`, 32-bit wrap with no overflow flag.
  - `fetch_count` +1.
- Simultaneous push and pop:
  - The count is unchanged.
  - Push is allowed at count==2; the popped slot is reused.
  - FIFO order is preserved.
- `redirect_valid` high:
  - PC <= `redirect_pc`.
  - No push that cycle.
  - Queue count <= 0 at the next edge.
  - A pop in the same cycle counts as completed, i.e. decode took the head.
  - Redirect has priority over push, pop bookkeeping, and `fetch_en`.
- `fetch_en` low with no redirect:
  - PC holds and nothing is pushed.
  - The queue still drains via pops.
- Outputs `instr`/`instr_pc` are driven from the head register. When `instr_valid`=0 they hold their last value; they carry no meaning.
- The block generates no memory writes and no `current_instr_type`; those come from downstream stages.

## Timing
- Reset (asynchronous assert, `rst_n`=0):
  - PC=`RESET_PC`, so `PC_value`=`RESET_PC` immediately.
  - Queue count=0, `instr_valid`=0.
  - `instr`=0, `instr_pc`=0, `fetch_count`=0.
- Reset mid-operation discards all queued instructions and any pending redirect; no partial state survives.
- Fetch latency: an instruction sampled at edge N appears on `instr`/`instr_valid` after edge N.
  - First valid instruction: the first edge with `rst_n`=1 and `fetch_en`=1 pushes the word at `RESET_PC`; `instr_valid` rises after that edge.
- Sustained throughput with `instr_ready`=1: one instruction per cycle, PC advancing by `PC_STEP` every cycle.
- Back-pressure with `instr_ready`=0:
  - Two pushes fill the queue.
  - PC then stalls at start+2×`PC_STEP`.
  - `instr` stays stable on the oldest entry.
- Redirect latency:
  - The edge in which `redirect_valid` is sampled sets PC.
  - The next cycle pushes the target word.
  - The target instruction is valid 2 edges after the redirect edge.
  - `instr_valid`=0 for exactly 1 cycle in between.
- `instr_valid` never drops while the queue is non-empty, except via redirect or reset.

## Test plan
- Reset then stream:
  - Memory holds 32'h11,32'h22,32'h33 at addresses 0..2; `fetch_en`=1, `instr_ready`=1.
  - Expect `instr`=11,22,33 on consecutive cycles with `instr_pc`=0,1,2.
  - Expect `fetch_count`=3 after 3 edges.
- Back-pressure:
  - `instr_ready`=0 from the start.
  - Expect count to saturate at 2, `PC_value` to hold at 2, and `instr`=11 stable.
  - Then raise `instr_ready`=1: expect 11,22,33 in order with no loss or duplication, and `PC_value` resuming at 3.
- Full plus simultaneous pop:
  - With the queue full, pulse `instr_ready` for 1 cycle.
  - Expect exactly one pop and one push; count stays 2; PC +1.
- Redirect:
  - Mid-stream, assert `redirect_valid` with `redirect_pc`=32'h40 (mem[0x40]=32'hAB) while the queue holds 2 entries.
  - Expect `instr_valid`=0 for 1 cycle, then `instr`=AB with `instr_pc`=0x40.
  - Expect no stale entries afterwards.
- Halt:
  - Deassert `fetch_en` with 2 entries queued and `instr_ready`=1.
  - Expect 2 pops, then `instr_valid`=0, with `PC_value` and `fetch_count` frozen.
- Reset mid-operation:
  - Drop `rst_n` asynchronously between edges with the queue full.
  - Expect `instr_valid`=0 and `PC_value`=`RESET_PC` immediately, before any clock edge.
  - After release, streaming restarts from mem[`RESET_PC`].
